ram16_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of one ram16 block (16-bit words, byte-addressed, writes bytes addr and addr+1).
- Port 0 is the CPU data side; port 1 is the peripheral/DMA side.
- Serialises their accesses into single-cycle RAM transactions.
- Returns a registered read word and a one-cycle ack to the granted requester.
- Fair round-robin arbitration by default.

---
 rtl/ram16_arbiter.sv | 122 ++++++++++++
 tb/tb_ram16_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ram16_arbiter.sv
// ram16_arbiter: two-port arbiter/sequencer in front of a single ram16.
// Each granted access gets one RAM cycle (ACCESS) followed by a one-cycle
// ack pulse (ACK). Simultaneous requests use round-robin arbitration. Define
// RAM16_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead.
module ram16_arbiter #(
  parameter int unsigned ADDR_SIZE = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [15:0]          wdata0,
  output logic                 ack0,
  output logic [15:0]          rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [15:0]          wdata1,
  output logic                 ack1,
  output logic [15:0]          rdata1,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [15:0]          ram_data_in,
  output logic                 ram_write_rq,
  output logic                 ram_output_en,
  input  logic [15:0]          ram_data_out,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

  state_e                 state_q;
  logic                   grant_q;       // port owning the current transaction
  logic                   ack0_q, ack1_q;
  logic [15:0]            rdata0_q, rdata1_q;
  logic [ADDR_SIZE-1:0]   ram_addr_q;
  logic [15:0]            ram_data_in_q;
  logic                   ram_write_rq_q, ram_output_en_q;
  logic                   busy_q;
  logic                   grant_d;       // winner if a grant happens this cycle
  logic                   any_req;
`ifndef RAM16_ARB_FIXED_PRIO_EN
  logic                   last_grant_q;
`endif

  // Arbitration: choose the winner among current requests
  always_comb begin
    any_req = req0 | req1;
`ifdef RAM16_ARB_FIXED_PRIO_EN
    grant_d = ~req0;
`else
    if (req0 && req1) grant_d = ~last_grant_q;
    else              grant_d = ~req0;
`endif
  end

  // Sequencer FSM: IDLE -> ACCESS (one RAM cycle) -> ACK (one-cycle ack)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      grant_q         <= 1'b0;
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      rdata0_q        <= '0;
      rdata1_q        <= '0;
      ram_addr_q      <= '0;
      ram_data_in_q   <= '0;
      ram_write_rq_q  <= 1'b0;
      ram_output_en_q <= 1'b0;
      busy_q          <= 1'b0;
`ifndef RAM16_ARB_FIXED_PRIO_EN
      last_grant_q    <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            ram_addr_q      <= grant_d ? addr1  : addr0;
            ram_data_in_q   <= grant_d ? wdata1 : wdata0;
            ram_write_rq_q  <= grant_d ? we1    : we0;
            ram_output_en_q <= grant_d ? ~we1   : ~we0;
            grant_q         <= grant_d;
`ifndef RAM16_ARB_FIXED_PRIO_EN
            last_grant_q    <= grant_d;
`endif
            busy_q          <= 1'b1;
            state_q         <= ACCESS;
          end
        end
        ACCESS: begin
          if (ram_output_en_q) begin
            if (grant_q) rdata1_q <= ram_data_out;
            else         rdata0_q <= ram_data_out;
          end
          ram_write_rq_q  <= 1'b0;
          ram_output_en_q <= 1'b0;
          ack0_q          <= ~grant_q;
          ack1_q          <= grant_q;
          state_q         <= ACK;
        end
        ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;
  assign ram_addr      = ram_addr_q;
  assign ram_data_in   = ram_data_in_q;
  assign ram_write_rq  = ram_write_rq_q;
  assign ram_output_en = ram_output_en_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ram16_arbiter.sv
// Directed self-checking bench for ram16_arbiter with a byte-wide ram16 model.
module tb_ram16_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [8:0]  ram_addr;
  logic [15:0] ram_data_in, ram_data_out;
  logic        ram_write_rq, ram_output_en, busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [0:511];
  logic [8:0] ram_addr_p1;

  always #5 clk = ~clk;

  ram16_arbiter #(.ADDR_SIZE(9)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_write_rq(ram_write_rq),
    .ram_output_en(ram_output_en), .ram_data_out(ram_data_out), .busy(busy)
  );

  // ram16 model: little-endian word, upper byte wraps at the top of memory
  assign ram_addr_p1  = ram_addr + 9'd1;
  assign ram_data_out = {mem[ram_addr_p1], mem[ram_addr]};
  always @(posedge clk) begin
    if (ram_write_rq) begin
      mem[ram_addr]    <= ram_data_in[7:0];
      mem[ram_addr_p1] <= ram_data_in[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Single access on one port with the other port idle
  task automatic xact(input int port, input logic we, input logic [8:0] addr,
                      input logic [15:0] data, input string tag);
    int   lat, wrq;
    logic got, other, oe_seen;
    logic [8:0]  addr_seen;
    logic [15:0] din_seen;
    @(negedge clk);
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; end
    else           begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; end
    lat = 0; wrq = 0; got = 1'b0; other = 1'b0;
    oe_seen = 1'bx; addr_seen = 'x; din_seen = 'x;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin oe_seen = ram_output_en; addr_seen = ram_addr; din_seen = ram_data_in; end
      if (ram_write_rq) wrq++;
      if ((port == 0) ? ack1 : ack0) other = 1'b1;
      got = (port == 0) ? ack0 : ack1;
    end
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    check({tag, " ack latency"}, lat, 2);
    check({tag, " write strobe cycles"}, wrq, we ? 1 : 0);
    check({tag, " output_en"}, {31'd0, oe_seen}, {31'd0, ~we});
    check({tag, " ram_addr"}, {23'd0, addr_seen}, {23'd0, addr});
    if (we) check({tag, " ram_data_in"}, {16'd0, din_seen}, {16'd0, data});
    check({tag, " other port ack"}, {31'd0, other}, 0);
    @(negedge clk);
    check({tag, " ack cleared"}, {30'd0, ack0, ack1}, 0);
    check({tag, " busy low in idle gap"}, {31'd0, busy}, 0);
  endtask

  int exp_order [8];
  int n, c0, c1, cyc;
  logic g;

  initial begin
    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
`ifdef RAM16_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 0);
    check("reset strobes", {28'd0, ram_write_rq, ram_output_en, ack0, ack1}, 0);
    check("reset ram_addr/data_in", {7'd0, ram_addr, ram_data_in}, 0);
    check("reset rdata", {rdata0, rdata1}, 0);
    reset = 1'b1;

    // Port 0 write then read back
    xact(0, 1'b1, 9'h010, 16'hBEEF, "p0 wr 010");
    check("mem 010/011", {16'd0, mem[9'h011], mem[9'h010]}, 32'h0000BEEF);
    check("rdata0 unchanged by write", {16'd0, rdata0}, 0);
    xact(0, 1'b0, 9'h010, 16'h0000, "p0 rd 010");
    check("rdata0 after read", {16'd0, rdata0}, 32'h0000BEEF);
    check("rdata1 untouched", {16'd0, rdata1}, 0);

    // Contention: both ports read continuously, 4 transactions each
    pulse_reset();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h011;
    n = 0; c0 = 0; c1 = 0; cyc = 0;
    while (n < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      check("ack overlap", {31'd0, ack0 & ack1}, 0);
      if (ack0 || ack1) begin
        g = ack1;
        check($sformatf("grant #%0d", n), {31'd0, g}, exp_order[n]);
        check("busy during ack", {31'd0, busy}, 1);
        if (g) begin
          c1++;
          check("contention rdata1", {16'd0, rdata1}, 32'h000000BE);
          if (c1 == 4) req1 = 1'b0;
        end else begin
          c0++;
          check("contention rdata0", {16'd0, rdata0}, 32'h0000BEEF);
          check("rdata1 before its read", {16'd0, rdata1}, (c1 > 0) ? 32'h000000BE : 32'h0);
          if (c0 == 4) req0 = 1'b0;
        end
        n++;
      end
    end
    check("contention transactions", n, 8);
    @(negedge clk);
    check("contention final idle", {31'd0, busy}, 0);

    // Odd-address write on port 1, read from port 0
    xact(1, 1'b1, 9'h021, 16'h1234, "p1 wr 021");
    check("rdata1 unchanged by write", {16'd0, rdata1}, 32'h000000BE);
    xact(0, 1'b0, 9'h020, 16'h0000, "p0 rd 020");
    check("rdata0 odd overlap", {16'd0, rdata0}, 32'h00003400);
    check("rdata1 undisturbed", {16'd0, rdata1}, 32'h000000BE);
    xact(1, 1'b0, 9'h021, 16'h0000, "p1 rd 021");
    check("rdata1 odd read", {16'd0, rdata1}, 32'h00001234);
    check("rdata0 undisturbed", {16'd0, rdata0}, 32'h00003400);

    // Top-of-memory wrap
    xact(0, 1'b1, 9'h1FF, 16'hA55A, "p0 wr 1FF");
    check("mem 1FF", {24'd0, mem[9'h1FF]}, 32'h5A);
    check("mem 000", {24'd0, mem[9'h000]}, 32'hA5);
    xact(0, 1'b0, 9'h000, 16'h0000, "p0 rd 000");
    check("rdata0 wrapped low byte", {16'd0, rdata0}, 32'h000000A5);
    xact(1, 1'b0, 9'h1FF, 16'h0000, "p1 rd 1FF");
    check("rdata1 wrapped word", {16'd0, rdata1}, 32'h0000A55A);

    // Reset during ACCESS of a write
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'h040; wdata0 = 16'hFFFF;
    @(negedge clk);
    check("write strobe before reset", {31'd0, ram_write_rq}, 1);
    reset = 1'b0;
    #1;
    check("async reset strobes", {28'd0, ram_write_rq, ram_output_en, ack0, ack1}, 0);
    check("async reset busy", {31'd0, busy}, 0);
    check("async reset addr/data", {7'd0, ram_addr, ram_data_in}, 0);
    check("async reset rdata", {rdata0, rdata1}, 0);
    req0 = 1'b0;
    @(negedge clk);
    check("no commit under reset", {16'd0, mem[9'h041], mem[9'h040]}, 0);
    check("no ack under reset", {30'd0, ack0, ack1}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("no ack after reset", {30'd0, ack0, ack1}, 0);
    check("idle after reset", {31'd0, busy}, 0);
    xact(0, 1'b0, 9'h040, 16'h0000, "p0 rd 040");
    check("rdata0 aborted write", {16'd0, rdata0}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
